// File: rtl/af_stream_unit_pkg.sv
// Shared definitions for the activation-function stream unit.
// Mode encodings and fixed-point constants derived from FRAC.
package af_stream_unit_pkg;

    typedef enum logic [1:0] {
        AF_BYPASS = 2'd0,
        AF_SIG    = 2'd1,
        AF_TANH   = 2'd2,
        AF_RELU   = 2'd3
    } af_mode_e;

    function automatic longint af_one(input int frac);
        return longint'(1) << frac;
    endfunction

    function automatic longint af_half(input int frac);
        return longint'(1) << (frac - 1);
    endfunction

endpackage

// File: rtl/af_lane.sv
// Single-channel combinational activation (bypass, sigmoid, tanh, relu).
// Works on a W+2 bit signed copy of x and saturates back to W bits.
module af_lane
    import af_stream_unit_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic [W-1:0] x_i,
    input  af_mode_e     mode_i,
    output logic [W-1:0] y_o
);

    localparam logic signed [W+1:0] ONE  = (W+2)'(af_one(FRAC));
    localparam logic signed [W+1:0] HALF = (W+2)'(af_half(FRAC));
    localparam logic signed [W+1:0] MAXV = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MINV = {3'b111, {(W-1){1'b0}}};

    logic signed [W+1:0] xe;
    logic signed [W+1:0] sh;
    logic signed [W+1:0] t;

    always_comb begin
        xe = {{2{x_i[W-1]}}, x_i};
        // arithmetic shift floors toward -inf
        sh = (xe >>> 2) + HALF;
        t  = xe;
        unique case (mode_i)
            AF_BYPASS: t = xe;
            AF_SIG:    t = (sh < 0) ? '0 : ((sh > ONE) ? ONE : sh);
            AF_TANH:   t = (xe < -ONE) ? -ONE : ((xe > ONE) ? ONE : xe);
            AF_RELU:   t = (xe < 0) ? '0 : xe;
            default:   t = xe;
        endcase
        if (t > MAXV) begin
            y_o = MAXV[W-1:0];
        end else if (t < MINV) begin
            y_o = MINV[W-1:0];
        end else begin
            y_o = t[W-1:0];
        end
    end

endmodule

// File: rtl/af_stream_unit.sv
// Two-stage valid/ready activation pipeline over CH channels.
// S1 holds the raw beat and mode, S2 the activated result.
module af_stream_unit
    import af_stream_unit_pkg::*;
#(
    parameter int W     = 32,
    parameter int FRAC  = 16,
    parameter int CH    = 100,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:CH*W-1]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:CH*W-1]   out_data,
    output logic [1:0]        out_mode,
    output logic [CNT_W-1:0]  beat_count,
    output logic              busy
);

    logic             s1_valid_q, s1_valid_d;
    logic [0:CH*W-1]  s1_data_q, s1_data_d;
    af_mode_e         s1_mode_q, s1_mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [0:CH*W-1]  s2_data_q, s2_data_d;
    af_mode_e         s2_mode_q, s2_mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:CH*W-1]  lane_y;
    logic             s1_en, s2_en;

    for (genvar k = 0; k < CH; k++) begin : g_lane
        af_lane #(
            .W    (W),
            .FRAC (FRAC)
        ) u_lane (
            .x_i    (s1_data_q[k*W +: W]),
            .mode_i (s1_mode_q),
            .y_o    (lane_y[k*W +: W])
        );
    end

    always_comb begin
        s2_en      = !s2_valid_q | out_ready;
        s1_en      = !s1_valid_q | s2_en;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_mode_d  = s2_mode_q;
        cnt_d      = cnt_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = af_mode_e'(mode);
            end
        end
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = lane_y;
                s2_mode_d = s1_mode_q;
            end
        end
        if (s2_valid_q & out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // flush drops in-flight beats but keeps data and the count
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s1_data_d  = s1_data_q;
            s1_mode_d  = s1_mode_q;
            s2_data_d  = s2_data_q;
            s2_mode_d  = s2_mode_q;
            cnt_d      = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= AF_BYPASS;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_mode_q  <= AF_BYPASS;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_mode_q  <= s2_mode_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = s1_en;
    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_mode   = s2_mode_q;
    assign beat_count = cnt_q;
    assign busy       = s1_valid_q | s2_valid_q;

endmodule
